// File: rtl/jump_instr_encoder.sv
// J/JAL encoder: turns (slot pc, absolute target) into a J-type word via a two-stage valid/ready pipe.
// Optional rejected-request counter enabled by defining JUMP_ENC_ERR_COUNT_EN.
module jump_instr_encoder #(
    parameter logic [5:0]  J_OPCODE   = 6'b000010,
    parameter logic [5:0]  JAL_OPCODE = 6'b000011
`ifdef JUMP_ENC_ERR_COUNT_EN
    ,
    parameter int unsigned ERR_CNT_W  = 8
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_target,
    input  logic                 in_link,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [1:0]           out_err
`ifdef JUMP_ENC_ERR_COUNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    localparam logic [31:0] REGION_MASK = 32'hF000_0000;

    logic        r_s1_valid;
    logic [31:0] r_s1_pc_plus4;
    logic [31:0] r_s1_target;
    logic        r_s1_link;

    logic        r_s2_valid;
    logic [31:0] r_instr;
    logic [1:0]  r_err;

    logic        w_s2_load;
    logic        w_in_xfer;
    logic [1:0]  w_err;
    logic [31:0] w_instr;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_load;
    assign w_in_xfer = in_valid && in_ready;

    // Encodability check and word formation from stage-1 contents.
    always_comb begin
        w_err    = 2'b00;
        w_instr  = 32'h0;
        w_err[0] = (r_s1_target[1:0] != 2'b00);
        w_err[1] = (((r_s1_target ^ r_s1_pc_plus4) & REGION_MASK) != 32'h0);
        if (w_err == 2'b00) begin
            w_instr = {(r_s1_link ? JAL_OPCODE : J_OPCODE), r_s1_target[27:2]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_pc_plus4 <= 32'h0;
            r_s1_target   <= 32'h0;
            r_s1_link     <= 1'b0;
        end else if (w_in_xfer) begin
            r_s1_valid    <= 1'b1;
            r_s1_pc_plus4 <= in_pc + 32'd4;
            r_s1_target   <= in_target;
            r_s1_link     <= in_link;
        end else if (w_s2_load) begin
            r_s1_valid    <= 1'b0;
        end
    end

    // Output stage holds its word while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_instr    <= 32'h0;
            r_err      <= 2'b00;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_instr <= w_instr;
                r_err   <= w_err;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_instr = r_instr;
    assign out_err   = r_err;

`ifdef JUMP_ENC_ERR_COUNT_EN
    logic [ERR_CNT_W-1:0] r_err_count;

    // Saturating count of rejected words actually handed to the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (r_s2_valid && out_ready && (r_err != 2'b00) && (r_err_count != '1)) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
        end
    end

    assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_jump_instr_encoder.sv
// Directed self-checking bench for jump_instr_encoder: vector table plus backpressure and reset sequences.
module tb_jump_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_target;
    logic        in_link;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [1:0]  out_err;
`ifdef JUMP_ENC_ERR_COUNT_EN
    logic [7:0]  err_count;
`endif

    int checks;
    int failures;

    jump_instr_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_target (in_target),
        .in_link   (in_link),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err)
`ifdef JUMP_ENC_ERR_COUNT_EN
        ,
        .err_count (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] target;
        logic        link;
        logic [31:0] exp_instr;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic send(input logic [31:0] pc, input logic [31:0] tgt, input logic link);
        int n;
        @(negedge clk);
        in_valid  = 1'b1;
        in_pc     = pc;
        in_target = tgt;
        in_link   = link;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("send_timeout", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] held;
        int n;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = 32'h0;
        in_target = 32'h0;
        in_link   = 1'b0;
        out_ready = 1'b1;

        vecs[0] = '{"j_basic",    32'h0040_0000, 32'h0040_0020, 1'b0, 32'h0810_0008, 2'b00};
        vecs[1] = '{"jal_basic",  32'h0040_0000, 32'h0040_0020, 1'b1, 32'h0C10_0008, 2'b00};
        vecs[2] = '{"misaligned", 32'h0040_0000, 32'h0040_0022, 1'b0, 32'h0000_0000, 2'b01};
        vecs[3] = '{"region",     32'h0FFF_FFFC, 32'h0FFF_FFF0, 1'b0, 32'h0000_0000, 2'b10};
        vecs[4] = '{"wrap",       32'hFFFF_FFFC, 32'h0000_0040, 1'b0, 32'h0800_0010, 2'b00};
        vecs[5] = '{"jal_top",    32'h0000_0000, 32'h0FFF_FFFC, 1'b1, 32'h0FFF_FFFF, 2'b00};
        vecs[6] = '{"both_err",   32'h0000_0000, 32'h1000_0001, 1'b1, 32'h0000_0000, 2'b11};

        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_err",   32'(out_err), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready), 32'h1);
`ifdef JUMP_ENC_ERR_COUNT_EN
        check("rst_err_count", 32'(err_count), 32'h0);
`endif

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].pc, vecs[i].target, vecs[i].link);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!out_valid && n < 20);
            check({vecs[i].name, "_latency"}, 32'(n), 32'd2);
            check({vecs[i].name, "_instr"}, out_instr, vecs[i].exp_instr);
            check({vecs[i].name, "_err"}, 32'(out_err), 32'(vecs[i].exp_err));
        end
        @(negedge clk);
        check("idle_out_valid", 32'(out_valid), 32'h0);
`ifdef JUMP_ENC_ERR_COUNT_EN
        check("err_count_after_table", 32'(err_count), 32'd3);
`endif

        // Backpressure: two accepted, third stalls, then drain in order.
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = vecs[0].pc; in_target = vecs[0].target; in_link = vecs[0].link;
        check("bp_ready_a", 32'(in_ready), 32'h1);
        @(negedge clk);
        in_pc = vecs[1].pc; in_target = vecs[1].target; in_link = vecs[1].link;
        check("bp_ready_b", 32'(in_ready), 32'h1);
        @(negedge clk);
        in_pc = vecs[4].pc; in_target = vecs[4].target; in_link = vecs[4].link;
        check("bp_ready_c_blocked", 32'(in_ready), 32'h0);
        check("bp_head_valid", 32'(out_valid), 32'h1);
        check("bp_head_instr", out_instr, vecs[0].exp_instr);
        held = out_instr;
        @(negedge clk);
        check("bp_still_blocked", 32'(in_ready), 32'h0);
        check("bp_instr_stable", out_instr, held);
        out_ready = 1'b1;
        #1 check("bp_full_accept", 32'(in_ready), 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_second_valid", 32'(out_valid), 32'h1);
        check("bp_second_instr", out_instr, vecs[1].exp_instr);
        @(negedge clk);
        check("bp_third_valid", 32'(out_valid), 32'h1);
        check("bp_third_instr", out_instr, vecs[4].exp_instr);
        @(negedge clk);
        check("bp_drained", 32'(out_valid), 32'h0);

        // Reset with two requests in flight.
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = vecs[0].pc; in_target = vecs[0].target; in_link = 1'b0;
        @(negedge clk);
        in_pc = vecs[1].pc; in_target = vecs[1].target; in_link = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("rp_full_valid", 32'(out_valid), 32'h1);
        check("rp_full_ready", 32'(in_ready), 32'h0);
        rst_n = 1'b0;
        #1;
        check("rp_out_valid_now", 32'(out_valid), 32'h0);
        check("rp_out_instr_now", out_instr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("rp_in_ready", 32'(in_ready), 32'h1);
        for (int k = 0; k < 4; k++) begin
            check("rp_no_stale", 32'(out_valid), 32'h0);
            @(negedge clk);
        end
`ifdef JUMP_ENC_ERR_COUNT_EN
        check("rp_err_count", 32'(err_count), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jump_instr_encoder.md
Name: jump_instr_encoder

Overview:
- Inverse of the datapath jump-address formation: takes a jump slot address and a desired absolute target, and produces the J-type instruction word (J or JAL) that reaches that target.
- Used by the instruction-memory loader/patcher path to emit jump words in-stream.
- Validates that the target is encodable: word-aligned, and in the same 256 MB region as slot PC+4.
- Two-stage valid/ready pipeline; sustains one request per cycle.

Parameters:
- J_OPCODE, 6'b000010, opcode field for plain jump.
- JAL_OPCODE, 6'b000011, opcode field for jump-and-link.
- ERR_CNT_W, 8, width of the rejected-request counter (optional feature only).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  encoder can accept request this cycle.
- in_pc  input  32  byte address of the jump instruction slot.
- in_target  input  32  desired absolute byte target.
- in_link  input  1  1 = JAL, 0 = J.
- out_valid  output  1  encoded word available.
- out_ready  input  1  consumer accepts word this cycle.
- out_instr  output  32  encoded instruction; 32'h0 (NOP) on error.
- out_err  output  2  bit0 = misaligned target, bit1 = region mismatch.
- err_count  output  ERR_CNT_W  rejected requests; present only with the optional feature.

Behaviour:
- Reset (async assert, sync-safe deassert): s1_valid=0, s2_valid=0, out_valid=0, out_instr=0, out_err=0, err_count=0. in_ready=1 after reset.
- Transfers: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready. Inputs sampled only on an input transfer.
- Stage 1 registers pc, target and link. Pc_plus4 = in_pc+4, modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
- Stage 2 computes and registers:
  - err[0] = (target[1:0] != 0).
  - err[1] = (target[31:28] != pc_plus4[31:28]).
  - If err == 0: out_instr = {link ? JAL_OPCODE : J_OPCODE, target[27:2]}. Otherwise out_instr = 32'h0.
- Stage advance: s2 loads when !s2_valid || out_ready. s1 advances into s2 under the same condition. in_ready = !s1_valid || (s2 loads this cycle).
- Latency: request accepted at cycle N gives out_valid at cycle N+2 when out_ready is held high. Throughput is 1 per cycle.
- Backpressure: with out_ready low, at most 2 requests are held. in_ready drops after the second acceptance. out_instr and out_err are stable while out_valid && !out_ready.
- Ordering is strict FIFO. No request is dropped or duplicated.
- Simultaneous output transfer and input accept in a full pipe: both occur in the same cycle, and occupancy is unchanged.
- Error requests still occupy a slot and still complete a handshake. They are never silently discarded.
- Reset asserted mid-operation discards all in-flight requests immediately. Outputs go to reset values.

Optional Feature:
- Macro: JUMP_ENC_ERR_COUNT_EN.
- Defined: err_count port exists. It increments by 1 on each output transfer with out_err != 0. It saturates at all-ones and clears only on reset.
- Undefined: err_count port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then pc=0x00400000, target=0x00400020, link=0, out_ready=1 -> 2 cycles later out_valid=1, out_instr=0x08100008, out_err=00.
- Same request with link=1 -> out_instr=0x0C100008, out_err=00.
- Misaligned target: target=0x00400022 -> out_instr=0x00000000, out_err=01. Region mismatch: pc=0x0FFFFFFC (PC+4=0x10000000), target=0x0FFFFFF0 -> out_err=10, instr 0. With the feature enabled, err_count=2 after both.
- Wrap: pc=0xFFFFFFFC, target=0x00000040 -> out_err=00, out_instr=0x08000010.
- Backpressure: out_ready=0 while driving 3 back-to-back requests -> first 2 accepted, in_ready=0 on third, out_instr stable. Release out_ready -> the three words emerge in order, one per cycle.
- Reset pulse with 2 requests in flight -> out_valid=0 immediately, in_ready=1 after release, no stale word emitted.
